// File: rtl/synth_pkg.sv
// synth_pkg: shared types for the voice allocator.
//   NOTE_W / OCT_W : note and octave code widths
//   voice_st_e     : per-voice state (FREE, HELD, RELEASING)
//   fsm_st_e       : control FSM state (IDLE, LOOKUP, APPLY)
//   event_t        : latched key event
package synth_pkg;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 3;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_st_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_APPLY  = 2'd2
  } fsm_st_e;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  oct;
  } event_t;
endpackage

// File: rtl/voice_picker.sv
// voice_picker: combinational target selector.
//   vst/note/oct/rank : per-voice state, stored note/octave, LRU rank
//   ev                : latched event
//   idx               : chosen voice
//   hit               : a target exists
//   stl               : target was in use and is being reassigned
// Note-on priority: retrigger match, lowest FREE, oldest RELEASING, oldest HELD.
// Note-off: the HELD voice carrying the same note/octave.
module voice_picker
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = $clog2(NUM_VOICES),
  parameter int RANK_W     = $clog2(NUM_VOICES)
) (
  input  voice_st_e [NUM_VOICES-1:0]             vst,
  input  logic      [NUM_VOICES-1:0][NOTE_W-1:0] note,
  input  logic      [NUM_VOICES-1:0][OCT_W-1:0]  oct,
  input  logic      [NUM_VOICES-1:0][RANK_W-1:0] rank,
  input  event_t                                 ev,
  output logic      [IDX_W-1:0]                  idx,
  output logic                                   hit,
  output logic                                   stl
);
  logic [NUM_VOICES-1:0] match;
  logic [RANK_W-1:0]     best;
  logic                  found;
  logic                  have;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++)
      match[i] = (note[i] == ev.note) && (oct[i] == ev.oct);
  end

  always_comb begin
    idx   = '0;
    stl   = 1'b0;
    found = 1'b0;
    have  = 1'b0;
    best  = '0;
    if (ev.on) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (!found && vst[i] != V_FREE && match[i]) begin
          idx = IDX_W'(i); found = 1'b1;
        end
      for (int i = 0; i < NUM_VOICES; i++)
        if (!found && vst[i] == V_FREE) begin
          idx = IDX_W'(i); found = 1'b1;
        end
      // Ranks are unique, so strict '<' picks exactly the oldest candidate.
      for (int i = 0; i < NUM_VOICES; i++)
        if (!found && vst[i] == V_RELEASING && (!have || rank[i] < best)) begin
          idx = IDX_W'(i); best = rank[i]; have = 1'b1;
        end
      if (have) begin found = 1'b1; stl = 1'b1; end
      for (int i = 0; i < NUM_VOICES; i++)
        if (!found && vst[i] == V_HELD && (!have || rank[i] < best)) begin
          idx = IDX_W'(i); best = rank[i]; have = 1'b1;
        end
      if (have) begin found = 1'b1; stl = 1'b1; end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (!found && vst[i] == V_HELD && match[i]) begin
          idx = IDX_W'(i); found = 1'b1;
        end
    end
    hit = found;
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller sharing NUM_VOICES voices.
//   clk, reset(active-low async)
//   ev_valid/ev_on/ev_note/ev_octave/ev_ready : event handshake (IDLE only)
//   rel_cycles  : busy time after note-off
//   voice_ld    : per-voice one-cycle load pulse
//   voice_gate  : per-voice key-held level
//   voice_note/voice_octave : packed per-voice note/octave
//   voice_busy  : voice HELD or RELEASING
//   steal       : one-cycle pulse when an in-use voice is reassigned
// FSM IDLE -> LOOKUP -> APPLY; all registers live here.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ev_valid,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [OCT_W-1:0]             ev_octave,
  output logic                         ev_ready,
  input  logic [30:0]                  rel_cycles,
  output logic [NUM_VOICES-1:0]        voice_ld,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [OCT_W*NUM_VOICES-1:0]  voice_octave,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         steal
);
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int RANK_W = $clog2(NUM_VOICES);

  fsm_st_e                                fsm;
  event_t                                 ev;
  voice_st_e [NUM_VOICES-1:0]             vst;
  logic      [NUM_VOICES-1:0][NOTE_W-1:0] vnote;
  logic      [NUM_VOICES-1:0][OCT_W-1:0]  voct;
  logic      [NUM_VOICES-1:0][RANK_W-1:0] rank;
  logic      [NUM_VOICES-1:0][30:0]       cnt;

  logic [IDX_W-1:0] pk_idx, tgt;
  logic             pk_hit, pk_stl, tgt_hit, tgt_stl;

  voice_picker #(.NUM_VOICES(NUM_VOICES)) u_picker (
    .vst (vst),
    .note(vnote),
    .oct (voct),
    .rank(rank),
    .ev  (ev),
    .idx (pk_idx),
    .hit (pk_hit),
    .stl (pk_stl)
  );

  assign ev_ready     = (fsm == S_IDLE);
  assign voice_note   = vnote;
  assign voice_octave = voct;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++)
      voice_busy[i] = (vst[i] != V_FREE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm        <= S_IDLE;
      ev         <= '0;
      tgt        <= '0;
      tgt_hit    <= 1'b0;
      tgt_stl    <= 1'b0;
      voice_ld   <= '0;
      voice_gate <= '0;
      steal      <= 1'b0;
      vnote      <= '0;
      voct       <= '0;
      cnt        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vst[i]  <= V_FREE;
        rank[i] <= RANK_W'(i);
      end
    end else begin
      voice_ld <= '0;
      steal    <= 1'b0;

      // Release countdown runs in every FSM state; APPLY below overrides it.
      for (int i = 0; i < NUM_VOICES; i++)
        if (vst[i] == V_RELEASING) begin
          if (cnt[i] == '0) vst[i] <= V_FREE;
          else              cnt[i] <= cnt[i] - 31'd1;
        end

      case (fsm)
        S_IDLE: if (ev_valid) begin
          ev  <= '{on: ev_on, note: ev_note, oct: ev_octave};
          fsm <= S_LOOKUP;
        end
        S_LOOKUP: begin
          tgt     <= pk_idx;
          tgt_hit <= pk_hit;
          tgt_stl <= pk_stl;
          fsm     <= S_APPLY;
        end
        S_APPLY: begin
          fsm <= S_IDLE;
          if (tgt_hit) begin
            if (ev.on) begin
              vst[tgt]        <= V_HELD;
              vnote[tgt]      <= ev.note;
              voct[tgt]       <= ev.oct;
              voice_gate[tgt] <= 1'b1;
              cnt[tgt]        <= '0;
              voice_ld[tgt]   <= 1'b1;
              steal           <= tgt_stl;
              // Target becomes newest; everything younger shifts down one.
              for (int j = 0; j < NUM_VOICES; j++) begin
                if (IDX_W'(j) == tgt)       rank[j] <= RANK_W'(NUM_VOICES - 1);
                else if (rank[j] > rank[tgt]) rank[j] <= rank[j] - 1'b1;
              end
            end else begin
              vst[tgt]        <= V_RELEASING;
              voice_gate[tgt] <= 1'b0;
              cnt[tgt]        <= rel_cycles;
            end
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [3:0]    ev_note = '0;
  logic [2:0]    ev_octave = '0;
  logic          ev_ready;
  logic [30:0]   rel_cycles = '0;
  logic [NV-1:0] voice_ld, voice_gate, voice_busy;
  logic [4*NV-1:0] voice_note;
  logic [3*NV-1:0] voice_octave;
  logic          steal;

  int n_cmp = 0;
  int n_fail = 0;
  logic rdy1, rdy2;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_on(ev_on),
    .ev_note(ev_note), .ev_octave(ev_octave), .ev_ready(ev_ready),
    .rel_cycles(rel_cycles), .voice_ld(voice_ld), .voice_gate(voice_gate),
    .voice_note(voice_note), .voice_octave(voice_octave),
    .voice_busy(voice_busy), .steal(steal)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns at the negedge after E2.
  task automatic send(input logic on, input logic [3:0] n, input logic [2:0] o);
    ev_valid = 1'b1; ev_on = on; ev_note = n; ev_octave = o;
    @(negedge clk);
    ev_valid = 1'b0; ev_note = 4'hF; ev_octave = 3'h7;
    rdy1 = ev_ready;
    @(negedge clk);
    rdy2 = ev_ready;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ev_ready, voice_ld, voice_gate, voice_busy, steal} !== {1'b1, 13'b0}) begin
      n_fail++; $display("FAIL reset_init: got %b want %b", {ev_ready, voice_ld, voice_gate, voice_busy, steal}, {1'b1, 13'b0}); end
    reset = 1'b1;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd7; ev_octave = 3'd2;
    @(negedge clk);
    ev_valid = 1'b0;
    n_cmp++; if (ev_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_lookup: ev_ready got %b want 0", ev_ready); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({ev_ready, voice_ld, voice_gate, voice_busy, steal} !== {1'b1, 13'b0}) begin
      n_fail++; $display("FAIL reset_mid: got %b want %b", {ev_ready, voice_ld, voice_gate, voice_busy, steal}, {1'b1, 13'b0}); end
    n_cmp++; if ({voice_note, voice_octave} !== 28'h0) begin
      n_fail++; $display("FAIL reset_note_oct: got %h want 0", {voice_note, voice_octave}); end
    n_cmp++; if (dut.rank !== 8'hE4) begin
      n_fail++; $display("FAIL reset_rank: got %h want e4", dut.rank); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if ({ev_ready, voice_ld, voice_busy, steal} !== {1'b1, 9'b0}) begin
        n_fail++; $display("FAIL reset_after: got %b want %b", {ev_ready, voice_ld, voice_busy, steal}, {1'b1, 9'b0}); end
    end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 4'(k + 1), 3'd4);
      n_cmp++; if (voice_ld !== 4'(1 << k) || steal !== 1'b0) begin
        n_fail++; $display("FAIL fill_ld%0d: ld=%b steal=%b want ld=%b steal=0", k, voice_ld, steal, 4'(1 << k)); end
    end
    @(negedge clk);
    n_cmp++; if (voice_ld !== 4'b0) begin
      n_fail++; $display("FAIL fill_ld_pulse: ld=%b want 0000", voice_ld); end
    n_cmp++; if ({voice_busy, voice_gate, voice_note, voice_octave} !== {4'hF, 4'hF, 16'h4321, 12'h924}) begin
      n_fail++; $display("FAIL fill_state: got %h want %h", {voice_busy, voice_gate, voice_note, voice_octave}, {4'hF, 4'hF, 16'h4321, 12'h924}); end
    n_cmp++; if (dut.rank !== 8'hE4) begin
      n_fail++; $display("FAIL fill_rank: got %h want e4", dut.rank); end
  endtask

  task automatic test_steal_held;
    send(1'b1, 4'd5, 3'd4);
    n_cmp++; if ({voice_ld, steal, voice_gate, voice_note} !== {4'b0001, 1'b1, 4'hF, 16'h4325}) begin
      n_fail++; $display("FAIL steal_held: got %h want %h", {voice_ld, steal, voice_gate, voice_note}, {4'b0001, 1'b1, 4'hF, 16'h4325}); end
    @(negedge clk);
    n_cmp++; if (steal !== 1'b0 || dut.rank !== 8'h93) begin
      n_fail++; $display("FAIL steal_pulse_rank: steal=%b rank=%h want 0/93", steal, dut.rank); end
  endtask

  task automatic test_release;
    rel_cycles = 31'd10;
    send(1'b0, 4'd2, 3'd4);
    n_cmp++; if ({voice_gate, voice_busy, voice_ld} !== {4'b1101, 4'hF, 4'h0}) begin
      n_fail++; $display("FAIL release_gate: got %b want %b", {voice_gate, voice_busy, voice_ld}, {4'b1101, 4'hF, 4'h0}); end
    repeat (10) @(negedge clk);
    n_cmp++; if (voice_busy !== 4'hF) begin
      n_fail++; $display("FAIL release_busy10: got %b want 1111", voice_busy); end
    @(negedge clk);
    n_cmp++; if (voice_busy !== 4'b1101) begin
      n_fail++; $display("FAIL release_busy11: got %b want 1101", voice_busy); end
    // Reoccupy voice 1, release again, then steal it while releasing.
    send(1'b1, 4'd2, 3'd4);
    n_cmp++; if ({voice_ld, steal} !== {4'b0010, 1'b0} || dut.rank !== 8'h4E) begin
      n_fail++; $display("FAIL release_refill: ld=%b steal=%b rank=%h want 0010/0/4e", voice_ld, steal, dut.rank); end
    send(1'b0, 4'd2, 3'd4);
    send(1'b1, 4'd6, 3'd4);
    n_cmp++; if ({voice_ld, steal, voice_gate, voice_note} !== {4'b0010, 1'b1, 4'hF, 16'h4365}) begin
      n_fail++; $display("FAIL steal_releasing: got %h want %h", {voice_ld, steal, voice_gate, voice_note}, {4'b0010, 1'b1, 4'hF, 16'h4365}); end
    repeat (12) @(negedge clk);
    n_cmp++; if (voice_busy !== 4'hF || dut.rank !== 8'h4E) begin
      n_fail++; $display("FAIL steal_rel_held: busy=%b rank=%h want 1111/4e", voice_busy, dut.rank); end
  endtask

  task automatic test_retrigger;
    send(1'b1, 4'd3, 3'd4);
    n_cmp++; if ({voice_ld, steal, voice_gate, voice_busy, voice_note, voice_octave} !== {4'b0100, 1'b0, 4'hF, 4'hF, 16'h4365, 12'h924}) begin
      n_fail++; $display("FAIL retrigger: got %h want %h", {voice_ld, steal, voice_gate, voice_busy, voice_note, voice_octave}, {4'b0100, 1'b0, 4'hF, 4'hF, 16'h4365, 12'h924}); end
    n_cmp++; if (dut.rank !== 8'h39) begin
      n_fail++; $display("FAIL retrigger_rank: got %h want 39", dut.rank); end
  endtask

  task automatic test_noop_off;
    send(1'b0, 4'd9, 3'd4);
    n_cmp++; if ({rdy1, rdy2, ev_ready} !== 3'b001) begin
      n_fail++; $display("FAIL noop_ready: got %b want 001", {rdy1, rdy2, ev_ready}); end
    n_cmp++; if ({voice_ld, steal, voice_gate, voice_busy, voice_note, voice_octave} !== {4'b0, 1'b0, 4'hF, 4'hF, 16'h4365, 12'h924}) begin
      n_fail++; $display("FAIL noop_outputs: got %h want %h", {voice_ld, steal, voice_gate, voice_busy, voice_note, voice_octave}, {4'b0, 1'b0, 4'hF, 4'hF, 16'h4365, 12'h924}); end
  endtask

  task automatic test_rel_zero;
    rel_cycles = 31'd0;
    send(1'b0, 4'd5, 3'd4);
    n_cmp++; if ({voice_gate, voice_busy} !== {4'b1110, 4'hF}) begin
      n_fail++; $display("FAIL rel0_first: got %b want %b", {voice_gate, voice_busy}, {4'b1110, 4'hF}); end
    @(negedge clk);
    n_cmp++; if (voice_busy !== 4'b1110 || voice_note !== 16'h4365) begin
      n_fail++; $display("FAIL rel0_free: busy=%b note=%h want 1110/4365", voice_busy, voice_note); end
  endtask

  task automatic test_back_to_back;
    ev_valid = 1'b1; ev_on = 1'b0; ev_note = 4'd9; ev_octave = 3'd1;
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (ev_ready !== logic'(i % 3 == 0) || voice_ld !== 4'b0) begin
        n_fail++; $display("FAIL b2b_%0d: ready=%b ld=%b want %b/0000", i, ev_ready, voice_ld, logic'(i % 3 == 0)); end
      @(negedge clk);
    end
    ev_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_steal_held;
    test_release;
    test_retrigger;
    test_noop_off;
    test_rel_zero;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphony controller that shares a pool of NUM_VOICES synth voice datapaths among incoming note-on/note-off events. It sits between the key/event decoder and the per-voice datapaths. For each voice it drives the note, octave, load strobe and gate (note_in) signals, tracks release time, and steals the least-recently-assigned voice when the pool is exhausted.

## Interface
- NUM_VOICES, 4, number of voice datapaths managed (2..8)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ev_valid  in  1  event present
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  4  note code
- ev_octave  in  3  octave code
- ev_ready  out  1  allocator can accept an event
- rel_cycles  in  31  cycles a voice stays busy after note-off
- voice_ld  out  NUM_VOICES  one-cycle pulse per voice: load note/octave
- voice_gate  out  NUM_VOICES  per-voice key-held level
- voice_note  out  4*NUM_VOICES  packed note per voice; voice i is at [4i+3:4i]
- voice_octave  out  3*NUM_VOICES  packed octave per voice; voice i is at [3i+2:3i]
- voice_busy  out  NUM_VOICES  voice is HELD or RELEASING
- steal  out  1  one-cycle pulse when an in-use voice was reassigned

## Operation
- Control FSM: IDLE → LOOKUP → APPLY → IDLE.
  - IDLE: ev_ready=1. Latches ev_on/ev_note/ev_octave when ev_valid is high.
  - LOOKUP: selects the target voice and registers the choice.
  - APPLY: commits the change.
- Per-voice state: FREE, HELD, RELEASING. Each voice has a 31-bit release counter and a LRU rank (0 = oldest, NUM_VOICES-1 = newest). Ranks are always a permutation of 0..NUM_VOICES-1.
- Note-on target selection, in priority order:
  1. A HELD or RELEASING voice with the same note and octave (retrigger).
  2. The lowest-index FREE voice.
  3. The RELEASING voice with the lowest rank.
  4. The HELD voice with the lowest rank. Cases 3 and 4 assert steal.
- Note-on APPLY:
  - Write note and octave to the target voice; state becomes HELD.
  - Set its gate to 1, clear its counter, pulse its voice_ld.
  - Set the target's rank to NUM_VOICES-1. Decrement every rank above the target's old rank.
- Note-off:
  - Target is the HELD voice whose note and octave match (at most one exists).
  - APPLY: gate becomes 0, state becomes RELEASING, counter loads rel_cycles. Ranks are unchanged and voice_ld does not pulse.
  - If no HELD voice matches, the event is consumed with no output change.
- Release countdown: a RELEASING voice decrements its counter every cycle in every FSM state. On the cycle its counter is 0, the voice becomes FREE and voice_busy drops.
- rel_cycles=0: the voice is RELEASING for exactly one cycle.
- A FREE voice keeps its last note and octave outputs.
- Simultaneous events: if an APPLY targets a voice whose timer expires in the same cycle, APPLY wins.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All voices FREE; note, octave and counters are 0.
  - Rank of voice i = i.
  - All outputs are 0 except ev_ready, which is 1.

## Timing
- Handshake: an event is accepted at a clk edge E0 where ev_valid && ev_ready.
- LOOKUP occupies the cycle after E0. APPLY commits at edge E2.
- voice_ld, steal, voice_gate, voice_busy and note/octave all change at E2. voice_ld and steal are high for exactly one cycle, E2 to E3.
- ev_ready is 0 from E0 to E2. Maximum throughput is one event per 3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Inputs are sampled only in IDLE. ev_note and ev_octave may change freely after acceptance.

## Structure
- Shared package synth_pkg holds:
  - NOTE_W=4 and OCT_W=3.
  - The voice state enum (FREE, HELD, RELEASING).
  - The FSM state enum (IDLE, LOOKUP, APPLY).
- Sub-module voice_picker: purely combinational priority/LRU selector.
  - Inputs: per-voice state, note, octave and rank, plus the latched event.
  - Outputs: target index, hit flag, steal flag.
- All registers live in voice_allocator.

## Test plan
- Reset mid-operation: assert reset during LOOKUP after a note-on → next edge shows ev_ready=1, all voice outputs 0, ranks reset to 0..3, and no voice_ld pulse.
- Four note-ons (notes 1,2,3,4, octave 4) with NUM_VOICES=4 → voices 0,1,2,3 each get one voice_ld pulse 2 edges after acceptance; voice_busy=4'b1111; steal never pulses.
- A fifth note-on (note 5) while all four are HELD → voice 0 (oldest) is reloaded with note 5, steal pulses once, voice_gate stays 4'b1111.
- Note-off for note 2 with rel_cycles=10 → voice 1 gate falls at E2; voice_busy[1] falls 11 cycles later. A note-on for note 6 arriving during the release takes the RELEASING voice 1 over HELD voices and pulses steal.
- Note-on for note 3 octave 4 while that note is already HELD on voice 2 → voice 2 retriggers: voice_ld[2] pulses, its rank becomes 3, no other voice changes, steal stays 0.
- Note-off for a note not held → ev_ready returns after 3 cycles and no output changes. Holding ev_valid constant high → events are accepted exactly every 3 cycles.
